// File: rtl/bus_interface_unit.sv
// rtl/bus_interface_unit.sv - 8088-style T1-T4 bus master for single-byte CPU requests
module bus_interface_unit #(
    parameter int MAX_WAIT     = 8,
    parameter int MEM_BANK_BIT = 19
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_io,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    input  logic        READY,
    output logic        ALE,
    output logic        RD,
    output logic        WR,
    output logic        IOM,
    output logic [19:0] Address,
    inout  wire  [7:0]  Data,
    output logic        CS_MEM0,
    output logic        CS_MEM1,
    output logic        CS_IO
);

    localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_TW,
        ST_T4
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           lat_write;
    logic           lat_io;
    logic [19:0]    lat_addr;
    logic [7:0]     lat_wdata;
    logic [WCW-1:0] wait_cnt;
    logic           accept;
    logic           sampling;
    logic           timeout;
    logic           busy;
    logic           strobe;
    logic           data_drive;

    assign req_ready = (state == ST_IDLE) || (state == ST_T4);
    assign accept    = req_valid && req_ready;
    assign sampling  = (state == ST_T3) || (state == ST_TW);
    // Abort only once MAX_WAIT wait states have already been spent in TW.
    assign timeout   = (state == ST_TW) && !READY && (wait_cnt == WAIT_MAX);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_T1;
            ST_T1:   state_nxt = ST_T2;
            ST_T2:   state_nxt = ST_T3;
            ST_T3, ST_TW: begin
                if (READY || timeout) state_nxt = ST_T4;
                else                  state_nxt = ST_TW;
            end
            ST_T4:   state_nxt = accept ? ST_T1 : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_IDLE;
            lat_write <= 1'b0;
            lat_io    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            wait_cnt  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_write <= req_write;
                lat_io    <= req_io;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (state_nxt == ST_T1) begin
                wait_cnt <= '0;
            end else if (sampling && !READY && (wait_cnt != WAIT_MAX)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (sampling) begin
                if (READY) begin
                    rsp_err <= 1'b0;
                    if (!lat_write) rsp_rdata <= Data;
                end else if (timeout) begin
                    rsp_rdata <= 8'hFF;
                    rsp_err   <= 1'b1;
                end
            end
        end
    end

    // Bus outputs decode straight from state so an asynchronous reset clears them at once.
    assign busy       = (state != ST_IDLE);
    assign strobe     = (state == ST_T2) || sampling;
    assign data_drive = lat_write && (strobe || (state == ST_T4));

    assign rsp_valid = (state == ST_T4);
    assign ALE       = (state == ST_T1);
    assign RD        = !(strobe && !lat_write);
    assign WR        = !(strobe && lat_write);
    assign IOM       = busy && lat_io;
    assign Address   = busy ? lat_addr : 20'h0;
    assign CS_MEM0   = busy && !lat_io && !lat_addr[MEM_BANK_BIT];
    assign CS_MEM1   = busy && !lat_io && lat_addr[MEM_BANK_BIT];
    assign CS_IO     = busy && lat_io;
    assign Data      = data_drive ? lat_wdata : 8'hzz;

endmodule

// File: tb/tb_bus_interface_unit.sv
// tb/tb_bus_interface_unit.sv - vector table and scoreboard bench for bus_interface_unit
module tb_bus_interface_unit;

    localparam int MAXW = 8;

    logic        CLK;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_io;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic        READY;
    logic        ALE;
    logic        RD;
    logic        WR;
    logic        IOM;
    logic [19:0] Address;
    wire  [7:0]  Data;
    logic        CS_MEM0;
    logic        CS_MEM1;
    logic        CS_IO;

    bus_interface_unit #(.MAX_WAIT(MAXW), .MEM_BANK_BIT(19)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .READY(READY), .ALE(ALE), .RD(RD), .WR(WR), .IOM(IOM),
        .Address(Address), .Data(Data),
        .CS_MEM0(CS_MEM0), .CS_MEM1(CS_MEM1), .CS_IO(CS_IO)
    );

    typedef struct {
        logic        wr;
        logic        io;
        logic [19:0] addr;
        logic [7:0]  wdata;
        int          nwait;
        logic [2:0]  cs;
        logic [7:0]  exp_rd;
        bit          chk_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [7:0] rd;
        bit         chk_rd;
        logic       err;
        int         lat;
        int         acc;
    } sb_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    sb_t  sbq[$];
    vec_t vt[9];
    vec_t bb[3];

    // Memory slave: two banks of 256 bytes, indexed by bank bit and low address byte.
    logic [7:0] mem [512];
    logic       probe_en;
    logic       slave_en;
    logic [8:0] midx;

    assign midx     = {Address[19], Address[7:0]};
    assign slave_en = !RD && (CS_MEM0 || CS_MEM1);
    assign Data     = slave_en ? mem[midx] : (probe_en ? 8'h3C : 8'hzz);

    always @(posedge CLK) if (!WR && (CS_MEM0 || CS_MEM1)) mem[midx] <= Data;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc = cyc + 1;

    function automatic logic [7:0] pre(input logic [19:0] a);
        return a[7:0] ^ (a[19] ? 8'hC3 : 8'h5A);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (!RESET && rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                if (e.chk_rd) chk("rsp_rdata", rsp_rdata, e.rd);
                chk("rsp_err", rsp_err, e.err);
                chk("rsp_latency", cyc - e.acc + 1, e.lat);
            end
        end
    end

    task automatic set_req(input vec_t v);
        req_write = v.wr;
        req_io    = v.io;
        req_addr  = v.addr;
        req_wdata = v.wdata;
    endtask

    task automatic push_exp(input vec_t v, input int acc);
        sb_t e;
        e.rd = v.exp_rd; e.chk_rd = v.chk_rd; e.err = v.exp_err;
        e.lat = v.exp_lat; e.acc = acc;
        sbq.push_back(e);
    endtask

    task automatic check_released(input string nm);
        probe_en = 1'b1;
        #1;
        chk(nm, Data, 8'h3C);
        probe_en = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int  j;
        bit  seen;
        for (j = 0; j < 20 && !req_ready; j++) @(negedge CLK);
        chk("ready_before_req", req_ready, 1'b1);
        set_req(v);
        req_valid = 1'b1;
        push_exp(v, cyc + 1);
        @(negedge CLK);
        req_valid = 1'b0;
        chk("t1_ale", ALE, 1'b1);
        chk("t1_addr", Address, v.addr);
        chk("t1_iom", IOM, v.io);
        chk("t1_cs", {CS_IO, CS_MEM1, CS_MEM0}, v.cs);
        chk("t1_ready", req_ready, 1'b0);
        @(negedge CLK);
        chk("t2_ale", ALE, 1'b0);
        chk("t2_strobes", {RD, WR}, v.wr ? 2'b10 : 2'b01);
        if (v.wr) chk("t2_data", Data, v.wdata);
        seen = 1'b0;
        for (j = 0; j < 30; j++) begin
            @(negedge CLK);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            chk("t3_strobes", {RD, WR}, v.wr ? 2'b10 : 2'b01);
            READY = (j >= v.nwait);
        end
        READY = 1'b1;
        chk("rsp_seen", seen, 1'b1);
        chk("t4_strobes", {RD, WR}, 2'b11);
        chk("t4_cs", {CS_IO, CS_MEM1, CS_MEM0}, v.cs);
        chk("t4_ready", req_ready, 1'b1);
        if (v.wr) chk("t4_data", Data, v.wdata);
        @(negedge CLK);
        chk("idle_cs", {CS_IO, CS_MEM1, CS_MEM0}, 3'b000);
        check_released("idle_data_released");
    endtask

    initial begin
        int k;
        int acc0;
        probe_en  = 1'b0;
        RESET     = 1'b1;
        READY     = 1'b1;
        req_valid = 1'b0;
        set_req('{1'b0, 1'b0, 20'h0, 8'h0, 0, 3'b0, 8'h0, 1'b0, 1'b0, 0});
        for (int i = 0; i < 512; i++) mem[i] = i[7:0] ^ (i[8] ? 8'hC3 : 8'h5A);

        vt[0] = '{1'b0, 1'b0, 20'h00010, 8'h00, 0,   3'b001, pre(20'h00010), 1'b1, 1'b0, 4};
        vt[1] = '{1'b1, 1'b0, 20'h80004, 8'hA5, 0,   3'b010, pre(20'h00010), 1'b1, 1'b0, 4};
        vt[2] = '{1'b0, 1'b0, 20'h80004, 8'h00, 0,   3'b010, 8'hA5,          1'b1, 1'b0, 4};
        vt[3] = '{1'b0, 1'b1, 20'h00060, 8'h00, 0,   3'b100, 8'h00,          1'b0, 1'b0, 4};
        vt[4] = '{1'b0, 1'b0, 20'h00011, 8'h00, 3,   3'b001, pre(20'h00011), 1'b1, 1'b0, 7};
        vt[5] = '{1'b0, 1'b0, 20'h80010, 8'h00, 255, 3'b010, 8'hFF,          1'b1, 1'b1, 4 + MAXW};
        vt[6] = '{1'b0, 1'b0, 20'h00012, 8'h00, 1,   3'b001, pre(20'h00012), 1'b1, 1'b0, 5};
        vt[7] = '{1'b1, 1'b0, 20'h00013, 8'h7E, 2,   3'b001, pre(20'h00012), 1'b1, 1'b0, 6};
        vt[8] = '{1'b0, 1'b0, 20'h00013, 8'h00, 0,   3'b001, 8'h7E,          1'b1, 1'b0, 4};

        bb[0] = '{1'b0, 1'b0, 20'h00001, 8'h00, 0, 3'b001, pre(20'h00001), 1'b1, 1'b0, 4};
        bb[1] = '{1'b1, 1'b0, 20'h80020, 8'h66, 0, 3'b010, pre(20'h00001), 1'b1, 1'b0, 4};
        bb[2] = '{1'b0, 1'b0, 20'h80020, 8'h00, 0, 3'b010, 8'h66,          1'b1, 1'b0, 4};

        #1;
        chk("rst_ale", ALE, 1'b0);
        chk("rst_strobes", {RD, WR}, 2'b11);
        chk("rst_iom", IOM, 1'b0);
        chk("rst_addr", Address, 20'h0);
        chk("rst_cs", {CS_IO, CS_MEM1, CS_MEM0}, 3'b000);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h0);
        check_released("rst_data_released");
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 9; i++) run_vec(vt[i]);

        // Back-to-back: req_valid stays high, each new accept must land in the previous T4.
        k = 0;
        acc0 = 0;
        set_req(bb[0]);
        req_valid = 1'b1;
        for (int t = 0; t < 40 && k < 3; t++) begin
            if (req_ready) begin
                push_exp(bb[k], cyc + 1);
                if (k == 0) acc0 = cyc + 1;
                else        chk("b2b_accept_gap", cyc + 1 - acc0, 4 * k);
                k++;
            end
            @(negedge CLK);
            if (k < 3) set_req(bb[k]);
            else       req_valid = 1'b0;
        end
        req_valid = 1'b0;
        chk("b2b_accepted", k, 3);
        repeat (6) @(negedge CLK);

        // Reset asserted during T3 of a write: the cycle is dropped with no response.
        set_req('{1'b1, 1'b0, 20'h00020, 8'h99, 0, 3'b001, 8'h0, 1'b0, 1'b0, 0});
        req_valid = 1'b1;
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        READY = 1'b0;
        @(negedge CLK);
        chk("pre_rst_wr_low", WR, 1'b0);
        RESET = 1'b1;
        #1;
        chk("midrst_strobes", {RD, WR}, 2'b11);
        chk("midrst_cs", {CS_IO, CS_MEM1, CS_MEM0}, 3'b000);
        chk("midrst_ale_iom", {ALE, IOM}, 2'b00);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_req_ready", req_ready, 1'b1);
        check_released("midrst_data_released");
        READY = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        run_vec(vt[0]);

        repeat (4) @(negedge CLK);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bus_interface_unit.md
# bus_interface_unit

Bus master that turns single-byte read/write requests from the CPU core model into 8088-style T1–T4 bus cycles on the shared system bus. It drives ALE, RD, WR, IOM, Address, Data and the device chip selects, and returns read data to the requester. It is the stage directly upstream of the memory and I/O slave models.

## Interface
Parameters:
- MAX_WAIT, default 8: maximum wait states (TW) inserted before a cycle is aborted with an error.
- MEM_BANK_BIT, default 19: address bit that selects between memory bank 0 and bank 1.

Ports (clock and reset first):
- CLK  input  1  single clock; all state changes on posedge.
- RESET  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_write  input  1  1 = write, 0 = read.
- req_io  input  1  1 = I/O space, 0 = memory space.
- req_addr  input  20  byte address.
- req_wdata  input  8  write data.
- rsp_valid  output  1  one-cycle pulse: cycle complete.
- rsp_rdata  output  8  read data; valid with rsp_valid.
- rsp_err  output  1  wait-state timeout; valid with rsp_valid.
- READY  input  1  slave ready, sampled in T3/TW; tie high when unused.
- ALE  output  1  address latch enable, high in T1 only.
- RD  output  1  read strobe, active-low.
- WR  output  1  write strobe, active-low.
- IOM  output  1  0 = memory cycle, 1 = I/O cycle.
- Address  output  20  bus address.
- Data  inout  8  bidirectional data bus; this unit drives it only for writes.
- CS_MEM0, CS_MEM1, CS_IO  output  1 each  active-high chip selects.

## Operation
- States: IDLE, T1, T2, T3, TW, T4.
- Handshake: a request is accepted at a posedge with req_valid && req_ready. Accepting latches req_write, req_io, req_addr and req_wdata. req_ready = 1 in IDLE and T4, 0 otherwise.
- IDLE: on accept, go to T1; otherwise stay in IDLE.
- T1: ALE=1. Address, IOM and CS are driven from the latched values. Go to T2.
- T2: ALE=0. For a read, RD=0; for a write, WR=0 and Data is driven with the latched wdata. Go to T3.
- T3 and TW: the strobe is held.
  - If READY=1: go to T4. For a read, Data is captured into rsp_rdata at this edge.
  - If READY=0: go to TW and increment the wait counter.
  - In TW, if the wait counter == MAX_WAIT and READY=0: go to T4 with an error. rsp_rdata = 8'hFF, rsp_err = 1.
- T4:
  - RD and WR return to 1. rsp_valid = 1 for this cycle only. Address, IOM and CS are still held.
  - Write data stays on Data through T4 and is released after T4.
  - Exit to T1 if a new request is accepted in T4 (back-to-back), else to IDLE.
- Chip selects (latched values, asserted T1–T4, 0 in IDLE):
  - CS_MEM0 = !io && !addr[MEM_BANK_BIT]
  - CS_MEM1 = !io && addr[MEM_BANK_BIT]
  - CS_IO = io
  - Exactly one chip select is high during a cycle.
- Wait counter: width clog2(MAX_WAIT+1). It clears on entry to T1 and saturates at MAX_WAIT.
- Data is high-Z in every state except T2–T4 of a write.

## Timing
- Reset values (applied asynchronously): state IDLE, ALE=0, RD=1, WR=1, IOM=0, Address=0, all CS=0, Data=Z, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
- Reset mid-cycle: all outputs go to reset values immediately. The request in flight is dropped with no rsp_valid.
- Zero-wait latency: accept edge → T1 → T2 → T3 → T4. rsp_valid is high 4 cycles after the accept edge.
- Each wait state adds 1 cycle. A timeout adds MAX_WAIT cycles.
- Back-to-back cycles: T4 is followed directly by T1, so there is a sustained rate of 1 transfer per 4 cycles.
- Slave alignment: the slave sees ALE with CS/IOM in T1 and the strobe low in T2.
  - For reads, the slave drives Data during T3, and the unit samples it at the T3→T4 edge.
  - For writes, the slave loads at the T3→T4 edge while Data is still driven.
- rsp_rdata holds its value until the next read completes. rsp_err clears on the next rsp_valid.

## Test plan
- Memory read, zero wait: req addr 20'h00010, read. Expect ALE high 1 cycle, CS_MEM0=1, IOM=0, RD low in T2–T3, rsp_valid 4 cycles after accept, rsp_rdata = byte preloaded at 0x00010.
- Memory write then read back: write 8'hA5 to 20'h80004. Expect CS_MEM1=1, WR low in T2–T3, Data=8'hA5 T2–T4, then Z. A subsequent read of 20'h80004 returns 8'hA5.
- I/O cycle: read with req_io=1 at 20'h00060. Expect IOM=1, CS_IO=1, both memory CS=0, and no memory slave responds.
- Wait states: READY held low for 3 cycles from T3. Expect 3 TW cycles, rsp_valid 7 cycles after accept, rsp_err=0. Holding READY low permanently gives rsp_err=1, rsp_rdata=8'hFF after MAX_WAIT TW cycles.
- Back-to-back: req_valid held high for 3 requests. Expect T4→T1 with no IDLE cycle, 3 rsp_valid pulses spaced exactly 4 cycles apart.
- Reset during T3 of a write: expect WR=1, Data=Z, all CS=0 with no clock edge, no rsp_valid, then a clean read after reset release.
